keypad_scan_debounce: RTL

Parametrised matrix-keypad scanner with integrated debounce, ghost-key rejection and optional auto-repeat. It drives one-hot active-high row strobes, samples pulled-down column inputs, and emits a single-cycle key event with a raw index and a mapped hex code. It sits between the keypad pins and the display/entry logic.

---
 rtl/keypad_scan_debounce_pkg.sv | 32 +++
 rtl/keypad_scan_debounce_tick_gen.sv | 29 ++
 rtl/keypad_scan_debounce.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_debounce_pkg.sv
// Shared types for the keypad scanner: FSM states, the 4x4 hex keymap and a
// one-hot to binary helper.
`default_nettype none

package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_e;

  // Row-major: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = E 0 F D
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic [31:0] onehot_index(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = 32'(i);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scan_debounce_tick_gen.sv
// Free-running divider: tick_o is high for one clk every SCAN_DIV clks.
`default_nettype none

module keypad_tick_gen #(
  parameter int SCAN_DIV = 16384
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == LAST);
    cnt_d  = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner with debounce, ghost rejection and single-shot key events.
// Define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.
`default_nettype none

module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 16384,
  parameter int DEB_TICKS    = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [COLS-1:0]               col_i,
  output logic [ROWS-1:0]               row_o,
  output logic                          pressed_o,
  output logic                          key_valid_o,
  output logic [$clog2(ROWS*COLS)-1:0]  key_idx_o,
  output logic [3:0]                    key_code_o
);

  localparam int IDX_W = $clog2(ROWS * COLS);
  localparam int DW    = $clog2(DEB_TICKS + 1);

  logic             tick;
  logic [COLS-1:0]  col_s1_q, col_s2_q;
  kp_state_e        state_q, state_d;
  logic [ROWS-1:0]  row_q, row_d;
  logic [COLS-1:0]  latch_q, latch_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       code_q, code_d;
  logic             w_onehot, w_accept, w_repeat;
  logic [ROWS-1:0]  w_row_rot;
  logic [IDX_W-1:0] w_key_idx;
  logic [3:0]       w_key_code;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .tick_o  (tick)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      col_s1_q <= '0;
      col_s2_q <= '0;
    end else begin
      col_s1_q <= col_i;
      col_s2_q <= col_s1_q;
    end
  end

  assign w_onehot  = (col_s2_q != '0) && ((col_s2_q & (col_s2_q - COLS'(1))) == '0);
  assign w_row_rot = {row_q[ROWS-2:0], row_q[ROWS-1]};
  // An accept only ever happens while the synchronized column equals the latched one-hot.
  assign w_key_idx = IDX_W'(onehot_index(32'(row_q)) * 32'(COLS) + onehot_index(32'(col_s2_q)));

  generate
    if (ROWS == 4 && COLS == 4) begin : g_hexmap
      assign w_key_code = KEYMAP[w_key_idx];
    end else begin : g_rawmap
      assign w_key_code = 4'(w_key_idx);
    end
  endgenerate

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= SCAN;
      row_q   <= ROWS'(1);
      latch_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    latch_d  = latch_q;
    cnt_d    = cnt_q;
    w_accept = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (w_onehot) begin
            latch_d = col_s2_q;
            if (DEB_TICKS == 1) begin
              w_accept = 1'b1;
              cnt_d    = '0;
              state_d  = HELD;
            end else begin
              cnt_d   = DW'(1);
              state_d = DEBOUNCE;
            end
          end else begin
            row_d = w_row_rot;
          end
        end
        DEBOUNCE: begin
          if (col_s2_q == latch_q) begin
            if (int'(cnt_q) + 1 == DEB_TICKS) begin
              w_accept = 1'b1;
              cnt_d    = '0;
              state_d  = HELD;
            end else begin
              cnt_d = cnt_q + DW'(1);
            end
          end else begin
            state_d = SCAN;
            row_d   = w_row_rot;
          end
        end
        HELD: begin
          // Only the latched column matters here; other keys are ignored.
          if ((col_s2_q & latch_q) == '0) begin
            if (int'(cnt_q) + 1 == DEB_TICKS) begin
              cnt_d   = '0;
              state_d = SCAN;
              row_d   = w_row_rot;
            end else begin
              cnt_d = cnt_q + DW'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign valid_d = w_accept | w_repeat;
  assign idx_d   = w_accept ? w_key_idx  : idx_q;
  assign code_d  = w_accept ? w_key_code : code_q;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_phase_q, rpt_phase_d;

  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;
    w_repeat    = 1'b0;
    if (w_accept) begin
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b0;
    end else if (tick && state_q == HELD) begin
      if (state_d != HELD) begin
        rpt_cnt_d   = '0;
        rpt_phase_d = 1'b0;
      end else if (int'(rpt_cnt_q) + 1 == (rpt_phase_q ? REPEAT_RATE : REPEAT_DELAY)) begin
        w_repeat    = 1'b1;
        rpt_cnt_d   = '0;
        rpt_phase_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end
`else
  logic w_repeat_unused;
  assign w_repeat_unused = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
  assign w_repeat        = 1'b0;
`endif

  always_comb begin
    row_o       = row_q;
    pressed_o   = (state_q == HELD);
    key_valid_o = valid_q;
    key_idx_o   = idx_q;
    key_code_o  = code_q;
  end

endmodule

`default_nettype wire
